// File: rtl/butterfly_rr_arbiter.sv
// butterfly_rr_arbiter: round-robin sharing of one b-lane butterfly unit among r requesters.
// Ports: clk, reset (sync, active-high); req_val/req_rdy + req_{ar,ac,br,bc,wr,wc} operands per
//   requester (element i*b+k = requester i, lane k); resp_val/resp_rdy per requester with a shared
//   resp_{cr,cc,dr,dc} bus and resp_id; bf_recv_* / bf_send_* handshake and data to the butterfly.
module butterfly_rr_arbiter #(
    parameter int n = 32,
    parameter int d = 16,
    parameter int b = 4,
    parameter int r = 3,
    localparam int iw = (r > 1) ? $clog2(r) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [r-1:0]     req_val,
    output logic [r-1:0]     req_rdy,
    input  logic [n*r*b-1:0] req_ar,
    input  logic [n*r*b-1:0] req_ac,
    input  logic [n*r*b-1:0] req_br,
    input  logic [n*r*b-1:0] req_bc,
    input  logic [n*r*b-1:0] req_wr,
    input  logic [n*r*b-1:0] req_wc,
    output logic [r-1:0]     resp_val,
    input  logic [r-1:0]     resp_rdy,
    output logic [n*b-1:0]   resp_cr,
    output logic [n*b-1:0]   resp_cc,
    output logic [n*b-1:0]   resp_dr,
    output logic [n*b-1:0]   resp_dc,
    output logic [iw-1:0]    resp_id,
    output logic             bf_recv_val,
    input  logic             bf_recv_rdy,
    output logic [n*b-1:0]   bf_ar,
    output logic [n*b-1:0]   bf_ac,
    output logic [n*b-1:0]   bf_br,
    output logic [n*b-1:0]   bf_bc,
    output logic [n*b-1:0]   bf_wr,
    output logic [n*b-1:0]   bf_wc,
    input  logic             bf_send_val,
    output logic             bf_send_rdy,
    input  logic [n*b-1:0]   bf_cr,
    input  logic [n*b-1:0]   bf_cc,
    input  logic [n*b-1:0]   bf_dr,
    input  logic [n*b-1:0]   bf_dc
);

    // d only documents the fixed-point format; it must still describe a sane format.
    if (r < 1 || b < 1 || d < 0 || d >= n) begin : g_bad_params
        $error("butterfly_rr_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [iw-1:0]  ptr;
    logic [iw-1:0]  owner;

    logic [n*b-1:0] op_ar;
    logic [n*b-1:0] op_ac;
    logic [n*b-1:0] op_br;
    logic [n*b-1:0] op_bc;
    logic [n*b-1:0] op_wr;
    logic [n*b-1:0] op_wc;

    logic [n*b-1:0] res_cr;
    logic [n*b-1:0] res_cc;
    logic [n*b-1:0] res_dr;
    logic [n*b-1:0] res_dc;

    // Grant search: rotate the request vector so that bit 0 is the
    // requester at ptr, take the first set bit, then rotate back.
    logic [2*r-1:0] req_dbl;
    logic [r-1:0]   req_rot;
    logic           found;
    logic [iw-1:0]  off;
    logic [iw:0]    gsum;
    logic [iw-1:0]  grant;
    logic [iw:0]    pinc;
    logic [iw-1:0]  ptr_nxt;

    assign req_dbl = {req_val, req_val} >> ptr;
    assign req_rot = req_dbl[r-1:0];

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int j = 0; j < r; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                off   = iw'(j);
            end
        end
    end

    assign gsum  = {1'b0, ptr} + {1'b0, off};
    assign grant = (gsum >= (iw+1)'(r)) ? iw'(gsum - (iw+1)'(r))
                                        : gsum[iw-1:0];

    assign pinc    = {1'b0, grant} + (iw+1)'(1);
    assign ptr_nxt = (pinc >= (iw+1)'(r)) ? '0 : pinc[iw-1:0];

    // Handshake qualifiers
    logic req_hs;
    logic own_rdy;
    logic cap;

    always_comb begin
        req_rdy  = '0;
        resp_val = '0;
        for (int i = 0; i < r; i++) begin
            req_rdy[i]  = (state == IDLE) && !reset && found
                          && (grant == iw'(i));
            resp_val[i] = (state == RESP) && (owner == iw'(i));
        end
    end

    assign req_hs  = |(req_val & req_rdy);
    // Only the owner's ready counts: resp_val is one-hot on the owner.
    assign own_rdy = |(resp_rdy & resp_val);
    assign cap     = (state == WAIT) && bf_send_val;

    // Operand mux for the granted requester
    logic [n*b-1:0] sel_ar;
    logic [n*b-1:0] sel_ac;
    logic [n*b-1:0] sel_br;
    logic [n*b-1:0] sel_bc;
    logic [n*b-1:0] sel_wr;
    logic [n*b-1:0] sel_wc;

    always_comb begin
        sel_ar = '0;
        sel_ac = '0;
        sel_br = '0;
        sel_bc = '0;
        sel_wr = '0;
        sel_wc = '0;
        for (int i = 0; i < r; i++) begin
            if (grant == iw'(i)) begin
                sel_ar = req_ar[i*n*b +: n*b];
                sel_ac = req_ac[i*n*b +: n*b];
                sel_br = req_br[i*n*b +: n*b];
                sel_bc = req_bc[i*n*b +: n*b];
                sel_wr = req_wr[i*n*b +: n*b];
                sel_wc = req_wc[i*n*b +: n*b];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and butterfly handshake outputs
    always_comb begin
        state_nxt   = state;
        bf_recv_val = 1'b0;
        bf_send_rdy = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_hs) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bf_recv_val = 1'b1;
                if (bf_recv_rdy) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                bf_send_rdy = 1'b1;
                if (bf_send_val) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Back to IDLE first; a request pending now is granted there.
                if (own_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pointer, owner, operand and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            owner  <= '0;
            op_ar  <= '0;
            op_ac  <= '0;
            op_br  <= '0;
            op_bc  <= '0;
            op_wr  <= '0;
            op_wc  <= '0;
            res_cr <= '0;
            res_cc <= '0;
            res_dr <= '0;
            res_dc <= '0;
        end else begin
            if (req_hs) begin
                ptr   <= ptr_nxt;
                owner <= grant;
                op_ar <= sel_ar;
                op_ac <= sel_ac;
                op_br <= sel_br;
                op_bc <= sel_bc;
                op_wr <= sel_wr;
                op_wc <= sel_wc;
            end
            if (cap) begin
                res_cr <= bf_cr;
                res_cc <= bf_cc;
                res_dr <= bf_dr;
                res_dc <= bf_dc;
            end
        end
    end

    assign bf_ar   = op_ar;
    assign bf_ac   = op_ac;
    assign bf_br   = op_br;
    assign bf_bc   = op_bc;
    assign bf_wr   = op_wr;
    assign bf_wc   = op_wc;

    assign resp_cr = res_cr;
    assign resp_cc = res_cc;
    assign resp_dr = res_dr;
    assign resp_dc = res_dc;
    assign resp_id = owner;

endmodule

// File: tb/tb_butterfly_rr_arbiter.sv
// tb_butterfly_rr_arbiter: directed bench for butterfly_rr_arbiter (n=32, d=16, b=2, r=3)
// with an attached b-cycle butterfly model and a transaction-level reference model.
module tb_butterfly_rr_arbiter;
    localparam int N = 32;
    localparam int D = 16;
    localparam int B = 2;
    localparam int R = 3;
    localparam int W = N * B;

    logic clk = 1'b0;
    logic reset;
    logic [R-1:0] req_val, req_rdy, resp_val, resp_rdy;
    logic [N*R*B-1:0] req_ar, req_ac, req_br, req_bc, req_wr, req_wc;
    logic [W-1:0] resp_cr, resp_cc, resp_dr, resp_dc;
    logic [1:0] resp_id;
    logic bf_recv_val, bf_recv_rdy, bf_send_val, bf_send_rdy;
    logic [W-1:0] bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc;
    logic [W-1:0] bf_cr, bf_cc, bf_dr, bf_dc;

    logic [31:0] st [6][R][B];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < R; gi++) begin : g_req
        for (genvar gk = 0; gk < B; gk++) begin : g_lane
            assign req_ar[(gi*B+gk)*N +: N] = st[0][gi][gk];
            assign req_ac[(gi*B+gk)*N +: N] = st[1][gi][gk];
            assign req_br[(gi*B+gk)*N +: N] = st[2][gi][gk];
            assign req_bc[(gi*B+gk)*N +: N] = st[3][gi][gk];
            assign req_wr[(gi*B+gk)*N +: N] = st[4][gi][gk];
            assign req_wc[(gi*B+gk)*N +: N] = st[5][gi][gk];
        end
    end

    butterfly_rr_arbiter #(.n(N), .d(D), .b(B), .r(R)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy),
        .req_ar(req_ar), .req_ac(req_ac), .req_br(req_br),
        .req_bc(req_bc), .req_wr(req_wr), .req_wc(req_wc),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_cr(resp_cr), .resp_cc(resp_cc),
        .resp_dr(resp_dr), .resp_dc(resp_dc), .resp_id(resp_id),
        .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy),
        .bf_ar(bf_ar), .bf_ac(bf_ac), .bf_br(bf_br),
        .bf_bc(bf_bc), .bf_wr(bf_wr), .bf_wc(bf_wc),
        .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy),
        .bf_cr(bf_cr), .bf_cc(bf_cc), .bf_dr(bf_dr), .bf_dc(bf_dc)
    );

    // Complex butterfly: c = a + w*b, d = a - w*b, Q(N-D).D fixed point.
    function automatic logic [31:0] bfl(input int sel,
        input logic [31:0] ar, input logic [31:0] ac,
        input logic [31:0] br, input logic [31:0] bc,
        input logic [31:0] wr, input logic [31:0] wc);
        longint pr, pc;
        pr = (longint'($signed(wr)) * longint'($signed(br))
            - longint'($signed(wc)) * longint'($signed(bc))) >>> D;
        pc = (longint'($signed(wr)) * longint'($signed(bc))
            + longint'($signed(wc)) * longint'($signed(br))) >>> D;
        case (sel)
            0: return ar + pr[31:0];
            1: return ac + pc[31:0];
            2: return ar - pr[31:0];
            default: return ac - pc[31:0];
        endcase
    endfunction

    // Attached butterfly: accepts when idle, result valid B cycles later.
    logic bf_busy = 1'b0;
    int   bf_cnt = 0;
    assign bf_recv_rdy = !bf_busy;
    assign bf_send_val = bf_busy && (bf_cnt == 0);

    always @(posedge clk) begin
        if (reset) begin
            bf_busy <= 1'b0;
            bf_cnt  <= 0;
        end else if (!bf_busy) begin
            if (bf_recv_val) begin
                bf_busy <= 1'b1;
                bf_cnt  <= B;
                for (int k = 0; k < B; k++) begin
                    bf_cr[k*N +: N] <= bfl(0, bf_ar[k*N +: N], bf_ac[k*N +: N],
                        bf_br[k*N +: N], bf_bc[k*N +: N], bf_wr[k*N +: N], bf_wc[k*N +: N]);
                    bf_cc[k*N +: N] <= bfl(1, bf_ar[k*N +: N], bf_ac[k*N +: N],
                        bf_br[k*N +: N], bf_bc[k*N +: N], bf_wr[k*N +: N], bf_wc[k*N +: N]);
                    bf_dr[k*N +: N] <= bfl(2, bf_ar[k*N +: N], bf_ac[k*N +: N],
                        bf_br[k*N +: N], bf_bc[k*N +: N], bf_wr[k*N +: N], bf_wc[k*N +: N]);
                    bf_dc[k*N +: N] <= bfl(3, bf_ar[k*N +: N], bf_ac[k*N +: N],
                        bf_br[k*N +: N], bf_bc[k*N +: N], bf_wr[k*N +: N], bf_wc[k*N +: N]);
                end
            end
        end else if (bf_cnt != 0) begin
            bf_cnt <= bf_cnt - 1;
        end else if (bf_send_rdy) begin
            bf_busy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: transaction phase 0 free, 1 offered to butterfly,
    // 2 butterfly computing, 3 result offered to owner.
    int m_stage = 0;
    int m_ptr = 0;
    int m_owner = 0;
    logic [31:0] m_op [6][B];
    logic [31:0] m_res [4][B];

    // Observed-event logs
    int gr_cyc[$];
    int gr_id[$];
    int rv_cyc[$];
    int rs_cnt = 0;
    int aborted = 0;
    logic rdy1_seen = 1'b0;
    logic [R-1:0] rise_val;
    logic [1:0] rise_id;
    logic [W-1:0] rise_cr, rise_cc, rise_dr, rise_dc;

    function automatic logic [63:0] pk_op(input int f);
        logic [63:0] v = '0;
        for (int k = 0; k < B; k++) v[k*N +: N] = m_op[f][k];
        return v;
    endfunction

    function automatic logic [63:0] pk_res(input int s);
        logic [63:0] v = '0;
        for (int k = 0; k < B; k++) v[k*N +: N] = m_res[s][k];
        return v;
    endfunction

    initial begin : compare
        int g, rv, idx, gid;
        logic [R-1:0] prev_rv;
        prev_rv = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            rv = int'(req_val);
            g = -1;
            if (!reset && m_stage == 0) begin
                for (int j = 0; j < R; j++) begin
                    idx = (m_ptr + j) % R;
                    if (g < 0 && ((rv >> idx) & 1) == 1) g = idx;
                end
            end
            chk("req_rdy", 64'(req_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("bf_recv_val", 64'(bf_recv_val), 64'(m_stage == 1));
            chk("bf_send_rdy", 64'(bf_send_rdy), 64'(m_stage == 2));
            chk("resp_val", 64'(resp_val), (m_stage == 3) ? (64'd1 << m_owner) : 64'd0);
            if (m_stage == 1) begin
                chk("bf_ar", bf_ar, pk_op(0));
                chk("bf_ac", bf_ac, pk_op(1));
                chk("bf_br", bf_br, pk_op(2));
                chk("bf_bc", bf_bc, pk_op(3));
                chk("bf_wr", bf_wr, pk_op(4));
                chk("bf_wc", bf_wc, pk_op(5));
            end
            if (m_stage == 3) begin
                chk("resp_id", 64'(resp_id), 64'(m_owner));
                chk("resp_cr", resp_cr, pk_res(0));
                chk("resp_cc", resp_cc, pk_res(1));
                chk("resp_dr", resp_dr, pk_res(2));
                chk("resp_dc", resp_dc, pk_res(3));
            end

            if ((req_val & req_rdy) != '0) begin
                gid = -1;
                for (int i = 0; i < R; i++) if (req_rdy[i]) gid = i;
                gr_cyc.push_back(cyc);
                gr_id.push_back(gid);
            end
            if ((resp_val & resp_rdy) != '0) rs_cnt++;
            if (resp_val != '0 && prev_rv == '0) begin
                rv_cyc.push_back(cyc);
                rise_val = resp_val;
                rise_id  = resp_id;
                rise_cr  = resp_cr;
                rise_cc  = resp_cc;
                rise_dr  = resp_dr;
                rise_dc  = resp_dc;
            end
            prev_rv = resp_val;
            if (req_rdy[1]) rdy1_seen = 1'b1;

            if (reset) begin
                m_stage = 0;
                m_ptr   = 0;
            end else begin
                case (m_stage)
                    0: if (g >= 0) begin
                        m_owner = g;
                        m_ptr   = (g + 1) % R;
                        for (int k = 0; k < B; k++) begin
                            for (int f = 0; f < 6; f++) m_op[f][k] = st[f][g][k];
                            for (int s = 0; s < 4; s++)
                                m_res[s][k] = bfl(s, m_op[0][k], m_op[1][k], m_op[2][k],
                                                  m_op[3][k], m_op[4][k], m_op[5][k]);
                        end
                        m_stage = 1;
                    end
                    1: if (bf_recv_rdy) m_stage = 2;
                    2: if (bf_send_val) m_stage = 3;
                    default: if (((int'(resp_rdy) >> m_owner) & 1) == 1) m_stage = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int cnt);
        int t = 0;
        while (gr_id.size() < cnt && t < 60) begin
            tick();
            t++;
        end
        chk("grant_wait", 64'(gr_id.size() >= cnt), 64'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (rs_cnt + aborted < gr_id.size() && t < 60) begin
            tick();
            t++;
        end
        chk("idle_wait", 64'(rs_cnt + aborted >= gr_id.size()), 64'd1);
        tick();
    endtask

    task automatic load(input int i);
        for (int k = 0; k < B; k++) begin
            st[0][i][k] = 32'(65536 * (i + 1) + 16384 * k);
            st[1][i][k] = 32'(32768 * k - 8192 * i);
            st[2][i][k] = 32'(131072 - 65536 * i + 4096 * k);
            st[3][i][k] = 32'(4096 * (i + k + 1));
            st[4][i][k] = 32'h0000B505;
            st[5][i][k] = 32'hFFFF4AFB;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base, t, nrise;
        logic [W-1:0] s_cr, s_dr;
        reset    = 1'b1;
        req_val  = '0;
        resp_rdy = 3'b111;
        for (int i = 0; i < R; i++) load(i);

        // Reset state, with all requesters already asking
        req_val = 3'b111;
        tick();
        tick();
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_bf_recv_val", 64'(bf_recv_val), 64'd0);
        chk("rst_bf_send_rdy", 64'(bf_send_rdy), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        tick();
        reset = 1'b0;

        // Round-robin: 0,1,2,0 every 6 cycles
        wait_grants(4);
        req_val = '0;
        chk("rr_g0", 64'(gr_id[0]), 64'd0);
        chk("rr_g1", 64'(gr_id[1]), 64'd1);
        chk("rr_g2", 64'(gr_id[2]), 64'd2);
        chk("rr_g3", 64'(gr_id[3]), 64'd0);
        for (int k = 0; k < 3; k++)
            chk("rr_period", 64'(gr_cyc[k+1] - gr_cyc[k]), 64'd6);
        wait_idle();

        // Pointer skip: ptr at 1, only 0 and 2 ask
        base = gr_id.size();
        rdy1_seen = 1'b0;
        req_val = 3'b101;
        wait_grants(base + 2);
        req_val = '0;
        chk("skip_g0", 64'(gr_id[base]), 64'd2);
        chk("skip_g1", 64'(gr_id[base+1]), 64'd0);
        chk("skip_no_rdy1", 64'(rdy1_seen), 64'd0);
        wait_idle();

        // Single transaction: 2.0 + 1.0*1.0 on every lane
        for (int k = 0; k < B; k++) begin
            st[0][1][k] = 32'h00020000;
            st[1][1][k] = 32'h0;
            st[2][1][k] = 32'h00010000;
            st[3][1][k] = 32'h0;
            st[4][1][k] = 32'h00010000;
            st[5][1][k] = 32'h0;
        end
        base = gr_id.size();
        req_val = 3'b010;
        wait_grants(base + 1);
        req_val = '0;
        wait_idle();
        chk("single_id", 64'(gr_id[base]), 64'd1);
        chk("single_latency", 64'(rv_cyc[rv_cyc.size()-1] - gr_cyc[base]), 64'd5);
        chk("single_resp_val", 64'(rise_val), 64'b010);
        chk("single_resp_id", 64'(rise_id), 64'd1);
        chk("single_cr", rise_cr, 64'h00030000_00030000);
        chk("single_cc", rise_cc, 64'd0);
        chk("single_dr", rise_dr, 64'h00010000_00010000);
        chk("single_dc", rise_dc, 64'd0);

        // Backpressure on owner 2; non-owners ready; requester 0 pending
        load(1);
        resp_rdy = 3'b000;
        base = gr_id.size();
        req_val = 3'b100;
        wait_grants(base + 1);
        req_val = 3'b001;
        t = 0;
        while (resp_val == '0 && t < 40) begin
            tick();
            t++;
        end
        chk("bp_resp_seen", 64'(resp_val), 64'b100);
        s_cr = resp_cr;
        s_dr = resp_dr;
        resp_rdy = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_val", 64'(resp_val), 64'b100);
            chk("bp_hold_cr", resp_cr, s_cr);
            chk("bp_hold_dr", resp_dr, s_dr);
            chk("bp_req_rdy", 64'(req_rdy), 64'd0);
            tick();
        end
        resp_rdy = 3'b111;
        @(negedge clk);
        chk("bp_last_val", 64'(resp_val), 64'b100);
        chk("bp_no_grant", 64'(req_rdy), 64'd0);
        tick();
        @(negedge clk);
        chk("bp_idle_val", 64'(resp_val), 64'd0);
        chk("bp_idle_rdy", 64'(req_rdy), 64'b001);
        tick();
        req_val = '0;
        wait_idle();

        // Reset while waiting on the butterfly
        base = gr_id.size();
        req_val = 3'b010;
        wait_grants(base + 1);
        req_val = '0;
        t = 0;
        while (!bf_send_rdy && t < 20) begin
            tick();
            t++;
        end
        chk("rw_in_wait", 64'(bf_send_rdy), 64'd1);
        nrise = rv_cyc.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        aborted = 1;
        @(negedge clk);
        chk("rw_resp_val", 64'(resp_val), 64'd0);
        chk("rw_send_rdy", 64'(bf_send_rdy), 64'd0);
        chk("rw_recv_val", 64'(bf_recv_val), 64'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("rw_no_resp", 64'(rv_cyc.size()), 64'(nrise));
        base = gr_id.size();
        req_val = 3'b110;
        wait_grants(base + 1);
        req_val = '0;
        chk("rw_ptr_zero", 64'(gr_id[base]), 64'd1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_rr_arbiter.md
Name: butterfly_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-butterfly unit (b lanes) among r independent requesters.
- Each requester offers a full b-lane operand set over val/rdy and gets its b-lane results back over val/rdy.
- Sits between the FFT stage controllers and the single shared butterfly datapath.
- One transaction is in flight at a time. Operands and results are registered in this block, so the butterfly inputs stay stable during its compute phase.

Parameters:
- n, 32, fixed-point bit width
- d, 16, fractional bits; passed through for documentation only, no arithmetic here
- b, 4, butterfly lanes per transaction; must match the attached butterfly
- r, 3, number of requesters (r >= 1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; also drives the attached butterfly's reset
- req_val  in  r  per-requester operand valid
- req_rdy  out  r  per-requester operand ready
- req_ar, req_ac, req_br, req_bc, req_wr, req_wc  in  n x (r*b)  operands; element i*b+k is requester i, lane k
- resp_val  out  r  per-requester result valid
- resp_rdy  in  r  per-requester result ready
- resp_cr, resp_cc, resp_dr, resp_dc  out  n x b  shared result bus; meaningful only where resp_val is high
- resp_id  out  max(1,clog2(r))  index of the requester owning the current result
- bf_recv_val  out  1  butterfly input valid
- bf_recv_rdy  in  1  butterfly input ready
- bf_ar, bf_ac, bf_br, bf_bc, bf_wr, bf_wc  out  n x b  butterfly operands, from the operand registers
- bf_send_val  in  1  butterfly result valid
- bf_send_rdy  out  1  butterfly result ready
- bf_cr, bf_cc, bf_dr, bf_dc  in  n x b  butterfly results

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP; 2-bit encoding.
- Registers: ptr (round-robin pointer), owner, operand registers, result registers.
- Reset:
  - state=IDLE, ptr=0, owner=0; all operand and result registers 0.
  - req_rdy=0, resp_val=0, bf_recv_val=0, bf_send_rdy=0, resp_id=0.
  - Reset mid-transaction abandons it with no response issued. The butterfly shares the reset, so no stale result survives.
- IDLE:
  - Combinational grant g = first i in ptr, ptr+1, ..., ptr+r-1 (mod r) with req_val[i]=1.
  - req_rdy[g]=1 only; all other req_rdy bits are 0. No request pending means all are 0.
  - On req_val[g] & req_rdy[g]: latch g's b lanes into the operand registers; owner<=g; ptr<=(g+1) mod r; next state ISSUE.
- ISSUE: bf_recv_val=1. On bf_recv_rdy go to WAIT; otherwise hold.
- WAIT:
  - bf_send_rdy=1.
  - On bf_send_val: capture bf_cr/cc/dr/dc into the result registers; go to RESP.
- RESP:
  - resp_val[owner]=1, all other resp_val bits 0; resp_id=owner; resp_* driven from the result registers.
  - On resp_rdy[owner] go to IDLE.
  - resp_rdy of non-owners is ignored.
- req_rdy is 0 outside IDLE. Requests arriving in ISSUE, WAIT or RESP wait. Requesters must hold req_val and operands until the handshake.
- Latency with the standard b-cycle butterfly:
  - Request handshake at cycle 0; bf handshake at cycle 1; bf DONE and capture at cycle b+2; resp_val high at cycle b+3.
  - With resp_rdy=1 the next request handshake is at cycle b+4, giving a period of b+4 cycles.
- Fairness:
  - A continuously requesting requester is granted within r transactions.
  - The pointer advances only on a grant.
- r=1: ptr is constant 0 and the grant reduces to req_val[0].
- Wrap-around: when g=r-1, ptr wraps to 0.
- Simultaneous resp_rdy[owner] and new req_val in RESP: no grant that cycle; the grant happens in the following IDLE cycle.

Test Plan:
- Config n=32, d=16, b=2, r=3.
- Single transaction:
  - Stimulus: requester 1, all lanes a=2.0 (0x00020000, ac=0), b=1.0, w=1.0 (0x00010000, wc=0); resp_rdy=1.
  - Required: resp_val[1] at handshake+5 cycles, resp_id=1, every lane cr=0x00030000, dr=0x00010000, cc=dc=0.
- Round-robin:
  - Stimulus: all three requesters asserted from reset with resp_rdy=1.
  - Required: grant order 0,1,2,0; consecutive req handshakes exactly 6 cycles apart.
- Pointer skip:
  - Stimulus: after a grant to 0, only requesters 0 and 2 are valid.
  - Required: next grant is 2, then 0; requester 1 never gets req_rdy.
- Response backpressure:
  - Stimulus: hold resp_rdy[owner]=0 for 4 cycles.
  - Required: resp_val and resp_* stable; req_rdy all 0; IDLE is entered one cycle after resp_rdy rises.
- Wrong-owner ready:
  - Stimulus: resp_rdy asserted only on a non-owner while in RESP.
  - Required: remains in RESP.
- Reset in WAIT:
  - Stimulus: assert reset for 1 cycle while in WAIT.
  - Required: the next cycle shows state IDLE, resp_val=0, ptr=0, and no response is delivered for the aborted request.
